// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO responder: register offsets,
// TCTRL bit positions and the compare-timer state encoding.
package dmem_mmio_pkg;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_TCMP   = 8'h0C;
    localparam logic [7:0] OFF_TCTRL  = 8'h10;
    localparam logic [7:0] OFF_TCNT   = 8'h14;
    localparam logic [7:0] OFF_ERRADR = 8'h18;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_FLAG = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: TCNT counts while enabled, reloads to 0 and raises FLAG when
// it matches TCMP. FLAG is cleared by writing 1 to the TCTRL FLAG bit.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcnt_we,
    input  logic        tcmp_we,
    input  logic        tctrl_we,
    input  logic [31:0] wdata,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic        en,
    output logic        flag
);

    timer_state_t state, state_n;
    logic [31:0]  tcnt_n, tcmp_n;
    logic         en_n, flag_n, expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
            tcmp  <= '0;
            en    <= 1'b0;
            flag  <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            tcmp  <= tcmp_n;
            en    <= en_n;
            flag  <= flag_n;
        end
    end

    // Expiry outranks a same-cycle W1C; a TCNT write outranks count/reload.
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        tcmp_n  = tcmp;
        en_n    = en;
        flag_n  = flag;
        expire  = (state != IDLE) && (tcnt == tcmp);

        case (state)
            RUN, EXPIRED: begin
                if (expire) begin
                    tcnt_n  = '0;
                    flag_n  = 1'b1;
                    state_n = EXPIRED;
                end else begin
                    tcnt_n = tcnt + 32'd1;
                end
            end
            default: ;
        endcase

        if (tctrl_we) begin
            en_n = wdata[TCTRL_EN];
            if (wdata[TCTRL_FLAG] && !expire) begin
                flag_n  = 1'b0;
                state_n = RUN;
            end
            if (!en_n) begin
                state_n = IDLE;
            end else if (state == IDLE) begin
                state_n = RUN;
            end
        end

        if (tcnt_we) begin
            tcnt_n = wdata;
        end
        if (tcmp_we) begin
            tcmp_n = wdata;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory target for the single-cycle MIPS core: word RAM plus an MMIO
// window (LEDs, switches, cycle counter, compare timer). Define ADDR_ERR_EN to
// enable the sticky address-error flag and ERRADR capture register.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
    parameter int unsigned SW_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwrite,
    input  logic [31:0]     dataadr,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    input  logic [SW_W-1:0] switches,
    output logic [SW_W-1:0] leds,
    output logic            timer_irq,
    output logic            addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]     mem [DEPTH];
    logic            ram_sel, mmio_sel, aligned, ram_we, mmio_we;
    logic [7:0]      off;
    logic [AW-1:0]   idx;
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic [31:0]     cycle, tcnt, tcmp, erradr;
    logic            t_en, t_flag;

    assign ram_sel  = dataadr < 32'(DEPTH * 4);
    assign mmio_sel = dataadr[31:8] == MMIO_BASE[31:8];
    assign aligned  = dataadr[1:0] == 2'b00;
    assign off      = dataadr[7:0];
    assign idx      = dataadr[AW+1:2];
    assign ram_we   = memwrite && aligned && ram_sel;
    assign mmio_we  = memwrite && aligned && mmio_sel;

    // RAM contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            cycle   <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            cycle   <= cycle + 32'd1;
            if (mmio_we && off == OFF_LED) begin
                leds <= writedata[SW_W-1:0];
            end
        end
    end

    mmio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .tcnt_we  (mmio_we && off == OFF_TCNT),
        .tcmp_we  (mmio_we && off == OFF_TCMP),
        .tctrl_we (mmio_we && off == OFF_TCTRL),
        .wdata    (writedata),
        .tcnt     (tcnt),
        .tcmp     (tcmp),
        .en       (t_en),
        .flag     (t_flag)
    );

    assign timer_irq = t_flag;

`ifdef ADDR_ERR_EN
    logic err_hit, err_clr;

    // Unmapped reads are not errors: the core presents an address every cycle.
    assign err_hit = !aligned || (memwrite && !ram_sel && !mmio_sel);
    assign err_clr = mmio_we && off == OFF_ERRADR;

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            addr_err <= 1'b0;
            erradr   <= '0;
        end else if (err_hit && !addr_err) begin
            addr_err <= 1'b1;
            erradr   <= dataadr;
        end
    end
`else
    assign addr_err = 1'b0;
    assign erradr   = '0;
`endif

    // Zero-latency read path required by the single-cycle core.
    always_comb begin
        readdata = '0;
        if (aligned) begin
            if (ram_sel) begin
                readdata = mem[idx];
            end else if (mmio_sel) begin
                case (off)
                    OFF_LED:    readdata = 32'(leds);
                    OFF_SW:     readdata = 32'(sw_sync);
                    OFF_CYCLE:  readdata = cycle;
                    OFF_TCMP:   readdata = tcmp;
                    OFF_TCTRL: begin
                        readdata[TCTRL_EN]   = t_en;
                        readdata[TCTRL_FLAG] = t_flag;
                    end
                    OFF_TCNT:   readdata = tcnt;
                    OFF_ERRADR: readdata = erradr;
                    default:    readdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, decode, LED/switch, cycle
// counter, compare timer, simultaneous events and mid-run reset.
module tb_dmem_mmio_responder;

    localparam logic [31:0] B = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr, writedata, readdata;
    logic [15:0] switches, leds;
    logic        timer_irq, addr_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] d;

    dmem_mmio_responder dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .switches  (switches),
        .leds      (leds),
        .timer_irq (timer_irq),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = v;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        dataadr = a;
        #1;
        v = readdata;
        dataadr = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (leds !== 16'h0) begin bad++; $display("FAIL reset_leds got=%h want=0000", leds); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", timer_irq); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b want=0", addr_err); end
        rd(B + 32'h10, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_tctrl got=%h want=0", d); end
    endtask

    // Runs immediately after test_reset, so CYCLE is known absolutely.
    task automatic test_cycle();
        rd(B + 32'h08, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL cycle_start got=%0d want=0", d); end
        repeat (5) @(posedge clk);
        #1;
        rd(B + 32'h08, d);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL cycle_count got=%0d want=5", d); end
        wr(B + 32'h08, 32'h0);
        rd(B + 32'h08, d);
        total++; if (d !== 32'd6) begin bad++; $display("FAIL cycle_write_ignored got=%0d want=6", d); end
    endtask

    task automatic test_ram();
        wr(32'h24, 32'h0BAD_BEEF);
        wr(32'h20, 32'h1234_5678);
        wr(32'h00, 32'h1111_2222);
        wr(32'hFC, 32'hFEDC_BA98);
        rd(32'h20, d);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL ram_20 got=%h want=12345678", d); end
        rd(32'h24, d);
        total++; if (d !== 32'h0BAD_BEEF) begin bad++; $display("FAIL ram_24 got=%h want=0badbeef", d); end
        rd(32'hFC, d);
        total++; if (d !== 32'hFEDC_BA98) begin bad++; $display("FAIL ram_top got=%h want=fedcba98", d); end
        wr(32'h100, 32'hDEAD_0000);
        rd(32'h100, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", d); end
        rd(32'h00, d);
        total++; if (d !== 32'h1111_2222) begin bad++; $display("FAIL unmapped_no_alias got=%h want=11112222", d); end
`ifdef ADDR_ERR_EN
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b want=1", addr_err); end
        rd(B + 32'h18, d);
        total++; if (d !== 32'h100) begin bad++; $display("FAIL unmapped_erradr got=%h want=100", d); end
        wr(B + 32'h18, 32'h0);
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", addr_err); end
`else
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL unmapped_err got=%b want=0", addr_err); end
`endif
    endtask

    task automatic test_misaligned();
        wr(32'h22, 32'hFFFF_FFFF);
        rd(32'h20, d);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL misaligned_store got=%h want=12345678", d); end
        rd(32'h22, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL misaligned_read got=%h want=0", d); end
        rd(B + 32'h01, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL misaligned_mmio got=%h want=0", d); end
`ifdef ADDR_ERR_EN
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL misaligned_err got=%b want=1", addr_err); end
        rd(B + 32'h18, d);
        total++; if (d !== 32'h22) begin bad++; $display("FAIL misaligned_erradr got=%h want=22", d); end
        wr(B + 32'h18, 32'h0);
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL misaligned_clear got=%b want=0", addr_err); end
`else
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL misaligned_err got=%b want=0", addr_err); end
        rd(B + 32'h18, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL erradr_absent got=%h want=0", d); end
`endif
    endtask

    task automatic test_led_switch();
        wr(B + 32'h00, 32'h0000_A5A5);
        total++; if (leds !== 16'hA5A5) begin bad++; $display("FAIL leds_a5a5 got=%h want=a5a5", leds); end
        wr(B + 32'h00, 32'hFFFF_1234);
        rd(B + 32'h00, d);
        total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL led_read got=%h want=00001234", d); end
        switches = 16'h00FF;
        rd(B + 32'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL sw_cycle0 got=%h want=0", d); end
        @(posedge clk);
        #1;
        rd(B + 32'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL sw_cycle1 got=%h want=0", d); end
        @(posedge clk);
        #1;
        rd(B + 32'h04, d);
        total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL sw_cycle2 got=%h want=000000ff", d); end
    endtask

    task automatic test_timer();
        wr(B + 32'h0C, 32'd3);
        wr(B + 32'h10, 32'h1);
        rd(B + 32'h14, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL timer_start got=%0d want=0", d); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            rd(B + 32'h14, d);
            total++; if (d !== 32'(i) || timer_irq !== 1'b0) begin bad++; $display("FAIL timer_count%0d got=%0d irq=%b want=%0d irq=0", i, d, timer_irq, i); end
        end
        @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (timer_irq !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL timer_expire irq=%b tcnt=%0d want irq=1 tcnt=0", timer_irq, d); end
        @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL timer_after_reload got=%0d want=1", d); end
        wr(B + 32'h10, 32'h3);
        rd(B + 32'h10, d);
        total++; if (timer_irq !== 1'b0 || d !== 32'h1) begin bad++; $display("FAIL timer_w1c irq=%b tctrl=%h want irq=0 tctrl=1", timer_irq, d); end
        @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL timer_pre_expire got=%0d want=3", d); end
    endtask

    task automatic test_simultaneous();
        wr(B + 32'h10, 32'h3);
        rd(B + 32'h14, d);
        total++; if (timer_irq !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL w1c_vs_expire irq=%b tcnt=%0d want irq=1 tcnt=0", timer_irq, d); end
        wr(B + 32'h14, 32'h10);
        rd(B + 32'h14, d);
        total++; if (d !== 32'h10) begin bad++; $display("FAIL tcnt_write got=%h want=10", d); end
        @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (d !== 32'h11) begin bad++; $display("FAIL tcnt_after_write got=%h want=11", d); end
        wr(B + 32'h10, 32'h0);
        rd(B + 32'h14, d);
        total++; if (timer_irq !== 1'b1 || d !== 32'h12) begin bad++; $display("FAIL disable_keeps_flag irq=%b tcnt=%h want irq=1 tcnt=12", timer_irq, d); end
        repeat (2) @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (d !== 32'h12) begin bad++; $display("FAIL idle_holds got=%h want=12", d); end
        wr(B + 32'h10, 32'h2);
        rd(B + 32'h10, d);
        total++; if (timer_irq !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL idle_w1c irq=%b tctrl=%h want irq=0 tctrl=0", timer_irq, d); end
        wr(B + 32'h0C, 32'h0);
        wr(B + 32'h14, 32'h0);
        wr(B + 32'h10, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        wr(B + 32'h10, 32'h3);
        rd(B + 32'h10, d);
        total++; if (timer_irq !== 1'b1 || d !== 32'h3) begin bad++; $display("FAIL tcmp0_flag irq=%b tctrl=%h want irq=1 tctrl=3", timer_irq, d); end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (leds !== 16'h0 || timer_irq !== 1'b0) begin bad++; $display("FAIL midreset_out leds=%h irq=%b want 0000 0", leds, timer_irq); end
        rd(B + 32'h08, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_cycle got=%h want=0", d); end
        rd(B + 32'h10, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_tctrl got=%h want=0", d); end
        repeat (2) @(posedge clk);
        #1;
        rd(B + 32'h14, d);
        total++; if (d !== 32'h0 || timer_irq !== 1'b0) begin bad++; $display("FAIL midreset_idle tcnt=%h irq=%b want 0 0", d, timer_irq); end
        rd(B + 32'h08, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL midreset_cycle_run got=%0d want=2", d); end
        rd(32'h20, d);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL ram_preserved got=%h want=12345678", d); end
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        switches  = 16'h0;
        test_reset();
        test_cycle();
        test_ram();
        test_misaligned();
        test_led_switch();
        test_timer();
        test_simultaneous();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
